// File: rtl/dance_monitor_if.sv
// LED pattern bus plus the monitor's decoded status outputs.
// The generator side drives led; the monitor side drives the rest.
interface dance_monitor_if #(
   parameter int unsigned N_LED = 18,
   parameter int unsigned CNT_W = 16
);
   logic [N_LED-1:0] led;
   logic [4:0]       pos;
   logic             pos_valid;
   logic [1:0]       dir;
   logic             wrap;
   logic             bounce;
   logic             err;
   logic             stalled;
   logic [CNT_W-1:0] step_count;
   logic [7:0]       err_count;

   modport master (
      output led,
      input  pos, pos_valid, dir, wrap, bounce, err, stalled, step_count, err_count
   );

   modport slave (
      input  led,
      output pos, pos_valid, dir, wrap, bounce, err, stalled, step_count, err_count
   );
endinterface

// File: rtl/dance_monitor.sv
// Observer for the 18-LED pattern bus: tracks the lit position and classifies
// each bus change as step, wrap, bounce or error, with counters and a stall flag.
module dance_monitor #(
   parameter int unsigned N_LED       = 18,
   parameter int unsigned STALL_LIMIT = 67108864,
   parameter int unsigned CNT_W       = 16
) (
   input  logic           Clock,
   input  logic           Resetn,
   dance_monitor_if.slave bus
);

   localparam int unsigned POS_W   = 5;
   localparam int unsigned ERR_W   = 8;
   localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

   localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(N_LED - 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
   localparam logic [1:0]         DIR_UNK   = 2'b00;
   localparam logic [1:0]         DIR_UP    = 2'b01;
   localparam logic [1:0]         DIR_DOWN  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_UNK,
      ST_UP,
      ST_DOWN
   } state_t;

   state_t             state_q, state_d;
   logic [N_LED-1:0]   last_led_q;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic               pos_valid_q, pos_valid_d;
   logic [1:0]         dir_q, dir_d;
   logic               wrap_q, wrap_d;
   logic               bounce_q, bounce_d;
   logic               err_q, err_d;
   logic               stalled_q, stalled_d;
   logic [CNT_W-1:0]   step_q, step_d;
   logic [ERR_W-1:0]   errc_q, errc_d;
   logic [STALL_W-1:0] stall_q, stall_d;

   logic               changed;
   logic               any_lit;
   logic               one_hot;
   logic               multi_hot;
   logic [POS_W-1:0]   hit_pos;
   logic               up_adj, dn_adj, wrap_up, wrap_dn;

   // Bus decode: one-hot/multi-hot detection and lit index.
   always_comb begin
      changed   = (bus.led != last_led_q);
      any_lit   = (bus.led != '0);
      one_hot   = any_lit && ((bus.led & (bus.led - N_LED'(1))) == '0);
      multi_hot = any_lit && !one_hot;
      hit_pos   = '0;
      for (int i = 0; i < N_LED; i++) begin
         if (bus.led[i]) hit_pos = POS_W'(i);
      end
   end

   // Transition classification against the held position.
   always_comb begin
      up_adj  = (pos_q < POS_MAX) && (hit_pos == pos_q + POS_W'(1));
      dn_adj  = (pos_q != '0) && (hit_pos == pos_q - POS_W'(1));
      wrap_up = (pos_q == POS_MAX) && (hit_pos == '0) && (state_q != ST_DOWN);
      wrap_dn = (pos_q == '0) && (hit_pos == POS_MAX) && (state_q != ST_UP);
   end

   // State register and all output flops.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q     <= ST_IDLE;
         last_led_q  <= '0;
         pos_q       <= '0;
         pos_valid_q <= 1'b0;
         dir_q       <= DIR_UNK;
         wrap_q      <= 1'b0;
         bounce_q    <= 1'b0;
         err_q       <= 1'b0;
         stalled_q   <= 1'b0;
         step_q      <= '0;
         errc_q      <= '0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         last_led_q  <= bus.led;
         pos_q       <= pos_d;
         pos_valid_q <= pos_valid_d;
         dir_q       <= dir_d;
         wrap_q      <= wrap_d;
         bounce_q    <= bounce_d;
         err_q       <= err_d;
         stalled_q   <= stalled_d;
         step_q      <= step_d;
         errc_q      <= errc_d;
         stall_q     <= stall_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      wrap_d    = 1'b0;
      bounce_d  = 1'b0;
      err_d     = 1'b0;
      stalled_d = stalled_q;
      step_d    = step_q;
      errc_d    = errc_q;
      stall_d   = stall_q;

      if (!changed) begin
         stall_d   = (stall_q == STALL_MAX) ? stall_q : stall_q + STALL_W'(1);
         stalled_d = (stall_d == STALL_MAX) &&
                     ((state_q == ST_UP) || (state_q == ST_DOWN));
      end else begin
         stall_d   = '0;
         stalled_d = 1'b0;
         if (multi_hot) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            errc_d  = (errc_q == '1) ? errc_q : errc_q + ERR_W'(1);
         end else if (one_hot) begin
            pos_d = hit_pos;
            if (state_q == ST_IDLE) begin
               state_d = ST_UNK;
            end else if (up_adj) begin
               state_d  = ST_UP;
               bounce_d = (state_q == ST_DOWN);
               step_d   = (step_q == '1) ? step_q : step_q + CNT_W'(1);
            end else if (dn_adj) begin
               state_d  = ST_DOWN;
               bounce_d = (state_q == ST_UP);
               step_d   = (step_q == '1) ? step_q : step_q + CNT_W'(1);
            end else if (wrap_up) begin
               state_d = ST_UP;
               wrap_d  = 1'b1;
               step_d  = (step_q == '1) ? step_q : step_q + CNT_W'(1);
            end else if (wrap_dn) begin
               state_d = ST_DOWN;
               wrap_d  = 1'b1;
               step_d  = (step_q == '1) ? step_q : step_q + CNT_W'(1);
            end else begin
               state_d = ST_UNK;
               err_d   = 1'b1;
               errc_d  = (errc_q == '1) ? errc_q : errc_q + ERR_W'(1);
            end
         end
      end

      pos_valid_d = (state_d != ST_IDLE);
      case (state_d)
         ST_UP:   dir_d = DIR_UP;
         ST_DOWN: dir_d = DIR_DOWN;
         default: dir_d = DIR_UNK;
      endcase
   end

   assign bus.pos        = pos_q;
   assign bus.pos_valid  = pos_valid_q;
   assign bus.dir        = dir_q;
   assign bus.wrap       = wrap_q;
   assign bus.bounce     = bounce_q;
   assign bus.err        = err_q;
   assign bus.stalled    = stalled_q;
   assign bus.step_count = step_q;
   assign bus.err_count  = errc_q;

endmodule

// File: tb/tb_dance_monitor.sv
// Bench for dance_monitor: directed scenarios plus a randomized run against a
// circular-position reference model.
module tb_dance_monitor;

   localparam int unsigned LIMIT = 8;
   localparam int unsigned NL    = 18;

   logic Clock = 1'b0;
   logic Resetn;
   int   total = 0;
   int   bad   = 0;

   always #5 Clock = ~Clock;

   dance_monitor_if bus ();

   dance_monitor #(
      .N_LED      (NL),
      .STALL_LIMIT(LIMIT),
      .CNT_W      (16)
   ) dut (
      .Clock (Clock),
      .Resetn(Resetn),
      .bus   (bus)
   );

   // Reference model: position on a ring of 18, direction as -1/0/+1.
   int          m_pos, m_valid, m_dir, m_cnt, m_steps, m_errs;
   bit          m_wrap, m_bounce, m_err, m_stalled;
   logic [17:0] m_last;

   function automatic logic [1:0] dir_bits(input int d);
      return (d == 1) ? 2'b01 : (d == -1) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [17:0] bit_at(input int p);
      logic [17:0] one;
      one = 18'd1;
      return one << p;
   endfunction

   task automatic model_edge(input logic rn, input logic [17:0] v);
      int p, diff, ones;
      m_wrap = 0; m_bounce = 0; m_err = 0;
      if (!rn) begin
         m_pos = 0; m_valid = 0; m_dir = 0; m_cnt = 0; m_steps = 0; m_errs = 0;
         m_stalled = 0; m_last = '0;
         return;
      end
      if (v == m_last) begin
         if (m_cnt < LIMIT) m_cnt++;
         m_stalled = (m_cnt == LIMIT) && (m_dir != 0);
      end else begin
         m_cnt = 0; m_stalled = 0;
         ones = $countones(v);
         if (ones > 1) begin
            m_err = 1; if (m_errs < 255) m_errs++;
            m_valid = 0; m_dir = 0;
         end else if (ones == 1) begin
            p = $clog2(v);
            if (!m_valid) begin
               m_dir = 0;
            end else begin
               diff = (p - m_pos + NL) % NL;
               if (diff == 1 && !(m_pos == NL - 1 && m_dir == -1)) begin
                  if (m_pos == NL - 1) m_wrap = 1; else m_bounce = (m_dir == -1);
                  m_dir = 1; if (m_steps < 65535) m_steps++;
               end else if (diff == NL - 1 && !(m_pos == 0 && m_dir == 1)) begin
                  if (m_pos == 0) m_wrap = 1; else m_bounce = (m_dir == 1);
                  m_dir = -1; if (m_steps < 65535) m_steps++;
               end else begin
                  m_err = 1; if (m_errs < 255) m_errs++;
                  m_dir = 0;
               end
            end
            m_pos = p; m_valid = 1;
         end
      end
      m_last = v;
   endtask

   // One clock edge with the given reset level and bus value; sampled #1 after.
   task automatic tick(input logic rn, input logic [17:0] v);
      Resetn  = rn;
      bus.led = v;
      @(posedge Clock);
      model_edge(rn, v);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b0, 18'h3ffff);
      tick(1'b0, '0);
      total++; if (bus.pos !== 5'd0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", bus.pos); end
      total++; if (bus.pos_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.pos_valid); end
      total++; if (bus.dir !== 2'b00) begin bad++; $display("FAIL reset_dir got=%b exp=00", bus.dir); end
      total++; if ({bus.wrap, bus.bounce, bus.err, bus.stalled} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.wrap, bus.bounce, bus.err, bus.stalled}); end
      total++; if (bus.step_count !== 16'd0 || bus.err_count !== 8'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.step_count, bus.err_count); end
   endtask

   task automatic test_sweep();
      int wraps;
      wraps = 0;
      tick(1'b0, '0);
      for (int i = 0; i < 18; i++) begin
         repeat (4) begin tick(1'b1, bit_at(i)); if (bus.wrap) wraps++; end
      end
      repeat (4) begin tick(1'b1, '0); if (bus.wrap) wraps++; end
      repeat (4) begin tick(1'b1, bit_at(0)); if (bus.wrap) wraps++; end
      total++; if (bus.pos !== 5'd0) begin bad++; $display("FAIL sweep_pos got=%0d exp=0", bus.pos); end
      total++; if (bus.dir !== 2'b01) begin bad++; $display("FAIL sweep_dir got=%b exp=01", bus.dir); end
      total++; if (bus.step_count !== 16'd18) begin bad++; $display("FAIL sweep_steps got=%0d exp=18", bus.step_count); end
      total++; if (wraps != 1) begin bad++; $display("FAIL sweep_wraps got=%0d exp=1", wraps); end
      total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL sweep_errs got=%0d exp=0", bus.err_count); end
   endtask

   task automatic test_bounce();
      tick(1'b0, '0);
      tick(1'b1, bit_at(5));
      tick(1'b1, bit_at(4));
      tick(1'b1, bit_at(3));
      total++; if (bus.dir !== 2'b10 || bus.step_count !== 16'd2) begin bad++; $display("FAIL down_walk got dir=%b steps=%0d exp dir=10 steps=2", bus.dir, bus.step_count); end
      total++; if (bus.bounce !== 1'b0) begin bad++; $display("FAIL down_no_bounce got=%b exp=0", bus.bounce); end
      tick(1'b1, bit_at(4));
      total++; if (bus.bounce !== 1'b1) begin bad++; $display("FAIL bounce_pulse got=%b exp=1", bus.bounce); end
      total++; if (bus.dir !== 2'b01 || bus.step_count !== 16'd3) begin bad++; $display("FAIL bounce_state got dir=%b steps=%0d exp dir=01 steps=3", bus.dir, bus.step_count); end
      tick(1'b1, bit_at(4));
      total++; if (bus.bounce !== 1'b0) begin bad++; $display("FAIL bounce_width got=%b exp=0", bus.bounce); end
   endtask

   task automatic test_jump();
      tick(1'b0, '0);
      tick(1'b1, bit_at(3));
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL acquire_no_err got=%b exp=0", bus.err); end
      tick(1'b1, bit_at(9));
      total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL jump_err got=%b exp=1", bus.err); end
      total++; if (bus.pos !== 5'd9 || bus.dir !== 2'b00 || bus.err_count !== 8'd1) begin bad++; $display("FAIL jump_state got pos=%0d dir=%b errc=%0d exp pos=9 dir=00 errc=1", bus.pos, bus.dir, bus.err_count); end
      tick(1'b1, bit_at(9));
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL jump_err_width got=%b exp=0", bus.err); end
      tick(1'b1, bit_at(10));
      total++; if (bus.dir !== 2'b01 || bus.err !== 1'b0) begin bad++; $display("FAIL jump_recover got dir=%b err=%b exp dir=01 err=0", bus.dir, bus.err); end
   endtask

   task automatic test_multihot();
      tick(1'b0, '0);
      tick(1'b1, bit_at(5));
      tick(1'b1, bit_at(6));
      tick(1'b1, 18'h00003);
      total++; if (bus.err !== 1'b1 || bus.pos_valid !== 1'b0 || bus.dir !== 2'b00) begin bad++; $display("FAIL multihot got err=%b valid=%b dir=%b exp 1/0/00", bus.err, bus.pos_valid, bus.dir); end
      total++; if (bus.pos !== 5'd6) begin bad++; $display("FAIL multihot_pos_hold got=%0d exp=6", bus.pos); end
      tick(1'b1, bit_at(7));
      total++; if (bus.pos !== 5'd7 || bus.pos_valid !== 1'b1 || bus.step_count !== 16'd1) begin bad++; $display("FAIL multihot_reacq got pos=%0d valid=%b steps=%0d exp 7/1/1", bus.pos, bus.pos_valid, bus.step_count); end
   endtask

   task automatic test_stall();
      tick(1'b0, '0);
      tick(1'b1, bit_at(1));
      tick(1'b1, bit_at(2));
      tick(1'b1, bit_at(3));
      for (int i = 1; i < LIMIT; i++) begin
         tick(1'b1, bit_at(3));
         total++; if (bus.stalled !== 1'b0) begin bad++; $display("FAIL stall_early hold=%0d got=%b exp=0", i, bus.stalled); end
      end
      tick(1'b1, bit_at(3));
      total++; if (bus.stalled !== 1'b1) begin bad++; $display("FAIL stall_assert got=%b exp=1", bus.stalled); end
      tick(1'b1, bit_at(3));
      total++; if (bus.stalled !== 1'b1) begin bad++; $display("FAIL stall_hold got=%b exp=1", bus.stalled); end
      tick(1'b1, bit_at(4));
      total++; if (bus.stalled !== 1'b0 || bus.step_count !== 16'd3) begin bad++; $display("FAIL stall_clear got stalled=%b steps=%0d exp 0/3", bus.stalled, bus.step_count); end
   endtask

   task automatic test_reset_mid();
      tick(1'b0, '0);
      tick(1'b1, bit_at(11));
      tick(1'b1, bit_at(12));
      total++; if (bus.pos !== 5'd12 || bus.dir !== 2'b01) begin bad++; $display("FAIL pre_reset got pos=%0d dir=%b exp 12/01", bus.pos, bus.dir); end
      tick(1'b0, bit_at(12));
      total++; if ({bus.pos, bus.pos_valid, bus.dir, bus.step_count, bus.err_count} !== '0) begin bad++; $display("FAIL mid_reset got pos=%0d valid=%b dir=%b steps=%0d errc=%0d exp all 0", bus.pos, bus.pos_valid, bus.dir, bus.step_count, bus.err_count); end
      tick(1'b1, bit_at(13));
      total++; if (bus.pos !== 5'd13 || bus.pos_valid !== 1'b1 || bus.dir !== 2'b00 || bus.step_count !== 16'd0) begin bad++; $display("FAIL post_reset_acq got pos=%0d valid=%b dir=%b steps=%0d exp 13/1/00/0", bus.pos, bus.pos_valid, bus.dir, bus.step_count); end
   endtask

   task automatic test_random();
      logic [17:0] v;
      int r, n, a, b;
      logic rn;
      tick(1'b0, '0);
      v = bit_at($urandom_range(0, 17));
      for (int it = 0; it < 700; it++) begin
         r  = $urandom_range(0, 99);
         n  = 1;
         rn = 1'b1;
         if (r < 2) begin
            rn = 1'b0;
         end else if (r < 10) begin
            n = $urandom_range(LIMIT - 1, LIMIT + 2);
         end else if (r < 55) begin
            a = (m_dir == -1) ? m_pos + NL - 1 : m_pos + 1;
            v = bit_at(a % NL);
         end else if (r < 70) begin
            a = (m_dir == 1) ? m_pos + NL - 1 : m_pos + 1;
            if ($urandom_range(0, 1) == 0) a = m_pos + NL - 1;
            v = bit_at(a % NL);
         end else if (r < 80) begin
            v = '0;
         end else if (r < 90) begin
            v = bit_at($urandom_range(0, 17));
         end else begin
            a = $urandom_range(0, 17);
            b = (a + $urandom_range(1, 17)) % NL;
            v = bit_at(a) | bit_at(b);
         end
         repeat (n) begin
            tick(rn, v);
            total++; if (bus.pos !== 5'(m_pos) || bus.pos_valid !== 1'(m_valid) || bus.dir !== dir_bits(m_dir)) begin bad++; $display("FAIL rnd_track it=%0d led=%h got pos=%0d valid=%b dir=%b exp pos=%0d valid=%0d dir=%b", it, v, bus.pos, bus.pos_valid, bus.dir, m_pos, m_valid, dir_bits(m_dir)); end
            total++; if ({bus.wrap, bus.bounce, bus.err, bus.stalled} !== {m_wrap, m_bounce, m_err, m_stalled}) begin bad++; $display("FAIL rnd_flags it=%0d led=%h got wbes=%b exp=%b", it, v, {bus.wrap, bus.bounce, bus.err, bus.stalled}, {m_wrap, m_bounce, m_err, m_stalled}); end
            total++; if (bus.step_count !== 16'(m_steps) || bus.err_count !== 8'(m_errs)) begin bad++; $display("FAIL rnd_counts it=%0d got steps=%0d errc=%0d exp steps=%0d errc=%0d", it, bus.step_count, bus.err_count, m_steps, m_errs); end
         end
      end
   endtask

   initial begin
      Resetn  = 1'b0;
      bus.led = '0;
      test_reset();
      test_sweep();
      test_bounce();
      test_jump();
      test_multihot();
      test_stall();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dance_monitor.md
Name: dance_monitor

Overview:
- Observer for the 18-LED pattern bus driven by the LED pattern generator; it is the reader side of that bus.
- Samples the `led` vector each clock, decodes the lit position, and classifies each change as one of: direction of travel, wrap-around, bounce, or pattern error.
- Provides step/error counters and a stall indication for on-board self-check and hex display.
- Sits beside the pattern generator in the same clock domain.

Parameters:
- N_LED, 18, width of the observed LED bus (position fields sized for 18; other values unsupported).
- STALL_LIMIT, 67108864, number of cycles without a bus change after which `stalled` asserts (2x generator step period).
- CNT_W, 16, width of `step_count`.

Ports:
- Clock, input, 1, system clock; all logic on the rising edge.
- Resetn, input, 1, synchronous active-low reset.
- led, input, 18, observed LED bus; synchronous to Clock.
- pos, output, 5, last decoded lit position 0..17.
- pos_valid, output, 1, `pos` holds a tracked position.
- dir, output, 2, 00 unknown, 01 up (index increasing), 10 down (index decreasing); 11 never driven.
- wrap, output, 1, one-cycle pulse on 17->0 (up) or 0->17 (down).
- bounce, output, 1, one-cycle pulse on direction reversal between adjacent positions.
- err, output, 1, one-cycle pulse on illegal transition.
- stalled, output, 1, level; no bus change for STALL_LIMIT cycles while `dir` != 00.
- step_count, output, CNT_W, legal steps seen; saturates at all-ones.
- err_count, output, 8, errors seen; saturates at 255.

Behaviour:
- Reset (Resetn low at an edge), all registers cleared:
  - pos = 0, pos_valid = 0, dir = 00.
  - wrap, bounce, err, stalled = 0.
  - Both counters = 0; last_led = 0; stall counter = 0.
- Reset mid-operation discards all tracking. The first one-hot after reset only acquires; it is never a step.
- All outputs are registered. Every edge samples `led` against `last_led`, then `last_led <= led`. A change presented before edge N is reflected on the outputs after edge N (one-cycle latency).
- Pulses (wrap, bounce, err) are high for exactly the one cycle after the classifying edge.
- No change (`led == last_led`): no event. The stall counter increments, saturating at STALL_LIMIT.
  - `stalled` = 1 when the counter equals STALL_LIMIT and dir != 00.
  - Any bus change clears the counter and `stalled` at that edge.
- Change to all-zero (gap): `pos`, `pos_valid` and `dir` are held; no event. Gaps may precede any one-hot value, and comparison is always against the held `pos`.
- Change to multi-hot (two or more bits set): err pulse, err_count += 1, pos_valid = 0, dir = 00, `pos` held.
- Change to one-hot at index p:
  - pos_valid = 0: acquire. pos = p, pos_valid = 1, dir = 00, no pulse, no count.
  - p == pos+1 (pos < 17): step up. dir = 01, step_count += 1. If previous dir was 10, also pulse bounce.
  - p == pos-1 (pos > 0): step down. dir = 10, step_count += 1. If previous dir was 01, also pulse bounce.
  - pos == 17, p == 0, previous dir in {00, 01}: wrap. dir = 01, step_count += 1.
  - pos == 0, p == 17, previous dir in {00, 10}: wrap. dir = 10, step_count += 1.
  - Any other p, including p == pos via a gap, and the wrap cases with the opposite previous dir: err pulse, err_count += 1, pos = p, pos_valid = 1, dir = 00.
  - Every legal case updates pos = p.
- Precedence: the wrap checks apply only to the 17/0 pairs. Adjacency checks cannot overlap them because of the pos range guards.
- At most one of wrap, bounce, err pulses per edge.
- State machine (encoded in pos_valid and dir):
  - IDLE (pos_valid = 0) -> UNK on one-hot.
  - UNK -> UP or DOWN on a legal step or wrap.
  - UP <-> DOWN on bounce.
  - Any state -> UNK on a jump error; any state -> IDLE on multi-hot or reset.
  - A gap keeps the current state.

Test Plan:
- Reset, then led = 1<<0, 1<<1 … 1<<17, 0, 1<<0, one change per 4 cycles -> after the sequence pos = 0, dir = 01, step_count = 18, exactly one wrap pulse, err_count = 0.
- Acquire at 1<<5, then 1<<4, 1<<3 -> dir = 10, step_count = 2; then 1<<4 -> bounce pulse, dir = 01, step_count = 3.
- Acquire at 1<<3, then 1<<9 -> err pulse one cycle after the change, pos = 9, dir = 00, err_count = 1; then 1<<10 -> dir = 01, no err.
- While tracking up, drive led = 18'h00003 -> err pulse, pos_valid = 0, dir = 00; then 1<<7 -> pos = 7, pos_valid = 1, step_count unchanged.
- STALL_LIMIT overridden to 8: after two up-steps, hold led constant 8 cycles -> stalled = 1; next legal change -> stalled = 0 after that edge.
- While tracking at pos = 12, dir = 01, assert Resetn = 0 for one edge -> all outputs zero; then 1<<13 -> acquire only (step_count = 0, dir = 00).
